// File: rtl/ex_mem_flags_stage.sv
// rtl/ex_mem_flags_stage.sv - EX/MEM pipeline register with NZCV flag register and branch resolution
//
// Captures the ALU result and control bits at the EX/MEM boundary, owns the
// architectural NZCV flags and resolves B, B.cond, CBZ and CBNZ into a
// registered taken/target pair for the fetch redirect.
//
// Optional feature macro: BRANCH_STATS_EN (adds the 32-bit taken_count output).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ex_valid                EX holds a live instruction
//   alu_*                   ALU result and N/Z/V/C flags
//   ex_set_flags            instruction writes NZCV
//   ex_is_uncond/bcond/cbz/cbnz, ex_cond, ex_branch_target   branch controls
//   ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write   forwarded controls
//   stall, flush            hold the stage / kill the EX instruction
//   mem_*                   registered outputs to MEM
//   flags                   architectural {N,Z,C,V}
//   taken_count             taken branches advanced into MEM (BRANCH_STATS_EN only)

module ex_mem_flags_stage #(
    parameter int BITS     = 64,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic [BITS-1:0]     alu_result,
    input  logic                alu_negative,
    input  logic                alu_zero,
    input  logic                alu_overflow,
    input  logic                alu_carry_out,
    input  logic                ex_set_flags,
    input  logic                ex_is_uncond,
    input  logic                ex_is_bcond,
    input  logic                ex_is_cbz,
    input  logic                ex_is_cbnz,
    input  logic [3:0]          ex_cond,
    input  logic [BITS-1:0]     ex_branch_target,
    input  logic [BITS-1:0]     ex_store_data,
    input  logic [REG_ADDR-1:0] ex_rd,
    input  logic                ex_reg_write,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic                stall,
    input  logic                flush,
    output logic                mem_valid,
    output logic [BITS-1:0]     mem_result,
    output logic [BITS-1:0]     mem_store_data,
    output logic [REG_ADDR-1:0] mem_rd,
    output logic                mem_reg_write,
    output logic                mem_mem_read,
    output logic                mem_mem_write,
    output logic                mem_branch_taken,
    output logic [BITS-1:0]     mem_branch_target,
    output logic [3:0]          flags
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]         taken_count
`endif
);

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_true;
    logic branch_taken;
    logic flags_we;

    // B.cond evaluates against the architectural flags, never this cycle's ALU flags.
    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    always_comb begin
        cond_true = 1'b0;
        case (ex_cond)
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = ~flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = ~flag_c;
            4'b0100: cond_true = flag_n;
            4'b0101: cond_true = ~flag_n;
            4'b0110: cond_true = flag_v;
            4'b0111: cond_true = ~flag_v;
            4'b1000: cond_true = flag_c & ~flag_z;
            4'b1001: cond_true = ~(flag_c & ~flag_z);
            4'b1010: cond_true = (flag_n == flag_v);
            4'b1011: cond_true = (flag_n != flag_v);
            4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_true = ~(~flag_z & (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
    end

    // CBZ/CBNZ rely on the ALU passing Rt through so alu_zero reflects Rt == 0.
    always_comb begin
        branch_taken = ex_valid & (ex_is_uncond
                                 | (ex_is_cbz   &  alu_zero)
                                 | (ex_is_cbnz  & ~alu_zero)
                                 | (ex_is_bcond &  cond_true));
    end

    assign flags_we = ex_valid & ex_set_flags & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid         <= 1'b0;
            mem_result        <= '0;
            mem_store_data    <= '0;
            mem_rd            <= '0;
            mem_reg_write     <= 1'b0;
            mem_mem_read      <= 1'b0;
            mem_mem_write     <= 1'b0;
            mem_branch_taken  <= 1'b0;
            mem_branch_target <= '0;
        end else if (flush) begin
            mem_valid        <= 1'b0;
            mem_reg_write    <= 1'b0;
            mem_mem_read     <= 1'b0;
            mem_mem_write    <= 1'b0;
            mem_branch_taken <= 1'b0;
        end else if (!stall) begin
            // Data registers load unconditionally; on a bubble they are don't-care.
            mem_valid         <= ex_valid;
            mem_result        <= alu_result;
            mem_store_data    <= ex_store_data;
            mem_rd            <= ex_rd;
            mem_reg_write     <= ex_valid & ex_reg_write;
            mem_mem_read      <= ex_valid & ex_mem_read;
            mem_mem_write     <= ex_valid & ex_mem_write;
            mem_branch_taken  <= branch_taken;
            mem_branch_target <= ex_branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (flags_we) begin
            flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_count <= '0;
        end else if (~flush & ~stall & branch_taken) begin
            taken_count <= taken_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_flags_stage.sv
// tb/tb_ex_mem_flags_stage.sv - scoreboard bench for ex_mem_flags_stage
module tb_ex_mem_flags_stage;

    localparam int BITS = 64;
    localparam int REG_ADDR = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset, ex_valid;
    logic [BITS-1:0]     alu_result;
    logic                alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic                ex_set_flags, ex_is_uncond, ex_is_bcond, ex_is_cbz, ex_is_cbnz;
    logic [3:0]          ex_cond;
    logic [BITS-1:0]     ex_branch_target, ex_store_data;
    logic [REG_ADDR-1:0] ex_rd;
    logic                ex_reg_write, ex_mem_read, ex_mem_write, stall, flush;
    logic                mem_valid;
    logic [BITS-1:0]     mem_result, mem_store_data;
    logic [REG_ADDR-1:0] mem_rd;
    logic                mem_reg_write, mem_mem_read, mem_mem_write, mem_branch_taken;
    logic [BITS-1:0]     mem_branch_target;
    logic [3:0]          flags;
`ifdef BRANCH_STATS_EN
    logic [31:0]         taken_count;
`endif

    ex_mem_flags_stage #(.BITS(BITS), .REG_ADDR(REG_ADDR)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .alu_result(alu_result),
        .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry_out(alu_carry_out), .ex_set_flags(ex_set_flags),
        .ex_is_uncond(ex_is_uncond), .ex_is_bcond(ex_is_bcond), .ex_is_cbz(ex_is_cbz),
        .ex_is_cbnz(ex_is_cbnz), .ex_cond(ex_cond), .ex_branch_target(ex_branch_target),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_branch_taken(mem_branch_taken),
        .mem_branch_target(mem_branch_target), .flags(flags)
`ifdef BRANCH_STATS_EN
        , .taken_count(taken_count)
`endif
    );

    typedef struct packed {
        logic                check_data;
        logic                valid;
        logic [BITS-1:0]     result;
        logic [BITS-1:0]     store_data;
        logic [REG_ADDR-1:0] rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                taken;
        logic [BITS-1:0]     target;
        logic [3:0]          flags;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   failures = 0;
    int   exp_count = 0;
    string vec_name;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per cycle presented by the stimulus side.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({vec_name, ".valid"},     64'(mem_valid),        64'(e.valid));
            check({vec_name, ".reg_write"}, 64'(mem_reg_write),    64'(e.reg_write));
            check({vec_name, ".mem_read"},  64'(mem_mem_read),     64'(e.mem_read));
            check({vec_name, ".mem_write"}, 64'(mem_mem_write),    64'(e.mem_write));
            check({vec_name, ".taken"},     64'(mem_branch_taken), 64'(e.taken));
            check({vec_name, ".flags"},     64'(flags),            64'(e.flags));
            if (e.check_data) begin
                check({vec_name, ".result"}, mem_result,         e.result);
                check({vec_name, ".store"},  mem_store_data,     e.store_data);
                check({vec_name, ".rd"},     64'(mem_rd),        64'(e.rd));
                check({vec_name, ".target"}, mem_branch_target,  e.target);
            end
        end
    end

    task automatic idle_inputs();
        reset = 0; ex_valid = 0; alu_result = '0;
        alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
        ex_set_flags = 0; ex_is_uncond = 0; ex_is_bcond = 0; ex_is_cbz = 0; ex_is_cbnz = 0;
        ex_cond = 4'd0; ex_branch_target = '0; ex_store_data = '0; ex_rd = '0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; stall = 0; flush = 0;
    endtask

    // Apply current inputs for one edge; exp_taken/exp_flags are hand-computed per vector.
    task automatic tick(input string name, input logic exp_taken, input logic [3:0] exp_flags);
        exp_t e;
        @(posedge clk);
        vec_name = name;
        if (reset) begin
            e = '0;
            e.check_data = 1'b1;
            exp_count = 0;
        end else if (!flush && stall) begin
            e = last_exp;
        end else if (flush || !ex_valid) begin
            e = last_exp;
            e.check_data = 1'b0;
            e.valid = 0; e.reg_write = 0; e.mem_read = 0; e.mem_write = 0; e.taken = 0;
            e.flags = exp_flags;
        end else begin
            e.check_data = 1'b1;
            e.valid = 1'b1;
            e.result = alu_result;
            e.store_data = ex_store_data;
            e.rd = ex_rd;
            e.reg_write = ex_reg_write;
            e.mem_read = ex_mem_read;
            e.mem_write = ex_mem_write;
            e.taken = exp_taken;
            e.target = ex_branch_target;
            e.flags = exp_flags;
            if (exp_taken) exp_count++;
        end
        last_exp = e;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic bcond(input string name, input logic [3:0] c, input logic t, input logic [3:0] f);
        idle_inputs();
        ex_valid = 1; ex_is_bcond = 1; ex_cond = c; ex_branch_target = 64'h4000 + 64'(c);
        tick(name, t, f);
    endtask

    initial begin
        idle_inputs();
        last_exp = '0;
        vec_name = "init";
        @(negedge clk);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            ex_valid = 1'($urandom); alu_result = {$urandom, $urandom};
            alu_zero = 1'($urandom); ex_set_flags = 1; ex_is_uncond = 1'($urandom);
            stall = 1'($urandom); flush = 1'($urandom); ex_reg_write = 1; ex_rd = 5'($urandom);
            reset = 1;
            tick("reset", 1'b0, 4'b0000);
        end

        idle_inputs();
        ex_valid = 1; alu_result = 64'h1234;
        tick("release", 1'b0, 4'b0000);

        // SUBS: N=0 Z=1 C=1 V=0 -> {N,Z,C,V}=0110
        idle_inputs();
        ex_valid = 1; ex_set_flags = 1; alu_zero = 1; alu_carry_out = 1;
        alu_result = 64'h0; ex_rd = 5'd3; ex_reg_write = 1;
        tick("subs1", 1'b0, 4'b0110);

        bcond("eq",  4'b0000, 1'b1, 4'b0110);
        bcond("ne",  4'b0001, 1'b0, 4'b0110);
        bcond("hs",  4'b0010, 1'b1, 4'b0110);
        bcond("hi",  4'b1000, 1'b0, 4'b0110);
        bcond("ls",  4'b1001, 1'b1, 4'b0110);
        bcond("al",  4'b1110, 1'b1, 4'b0110);

        // SUBS: N=1 V=0 -> 1000
        idle_inputs();
        ex_valid = 1; ex_set_flags = 1; alu_negative = 1; alu_result = 64'hFFFF_FFFF_FFFF_FFFE;
        tick("subs2", 1'b0, 4'b1000);
        bcond("lt", 4'b1011, 1'b1, 4'b1000);
        bcond("ge", 4'b1010, 1'b0, 4'b1000);
        bcond("gt", 4'b1100, 1'b0, 4'b1000);
        bcond("le", 4'b1101, 1'b1, 4'b1000);
        bcond("mi", 4'b0100, 1'b1, 4'b1000);

        // Branch with set_flags: old flags decide (Z=0 -> EQ not taken), flags still update
        idle_inputs();
        ex_valid = 1; ex_is_bcond = 1; ex_cond = 4'b0000; ex_set_flags = 1; alu_zero = 1;
        ex_branch_target = 64'h5000;
        tick("bc_setf", 1'b0, 4'b0100);
        bcond("eq2", 4'b0000, 1'b1, 4'b0100);

        // CBZ / CBNZ / B
        idle_inputs();
        ex_valid = 1; ex_is_cbz = 1; alu_zero = 1; ex_branch_target = 64'hABC0;
        tick("cbz_t", 1'b1, 4'b0100);
        idle_inputs();
        ex_valid = 1; ex_is_cbz = 1; alu_zero = 0; alu_result = 64'h7; ex_branch_target = 64'hABC4;
        tick("cbz_n", 1'b0, 4'b0100);
        idle_inputs();
        ex_valid = 1; ex_is_cbnz = 1; alu_zero = 0; alu_result = 64'h7; ex_branch_target = 64'hABC8;
        tick("cbnz_t", 1'b1, 4'b0100);
        idle_inputs();
        ex_valid = 1; ex_is_cbnz = 1; alu_zero = 1; ex_branch_target = 64'hABCC;
        tick("cbnz_n", 1'b0, 4'b0100);
        idle_inputs();
        ex_valid = 1; ex_is_uncond = 1; ex_branch_target = 64'hDEAD_BEEF_0000_1000;
        tick("b", 1'b1, 4'b0100);

        // Load/store controls pass through
        idle_inputs();
        ex_valid = 1; ex_mem_write = 1; ex_store_data = 64'hCAFE_F00D_1234_5678;
        alu_result = 64'h200; ex_rd = 5'd17;
        tick("stur", 1'b0, 4'b0100);
        idle_inputs();
        ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; alu_result = 64'h208; ex_rd = 5'd31;
        tick("ldur", 1'b0, 4'b0100);

        // Stall 3 cycles with a live flag-setting taken branch presented
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            ex_valid = 1; stall = 1; ex_set_flags = 1; alu_negative = 1; alu_overflow = 1;
            ex_is_uncond = 1; alu_result = 64'h9999; ex_reg_write = 1;
            tick("stall", 1'b0, 4'b0100);
        end

        // Flush a SUBS with reg_write
        idle_inputs();
        ex_valid = 1; flush = 1; ex_set_flags = 1; alu_carry_out = 1; alu_overflow = 1;
        ex_reg_write = 1; ex_is_uncond = 1; ex_mem_read = 1;
        tick("flush", 1'b0, 4'b0100);

        // Refill, then stall+flush together -> bubble
        idle_inputs();
        ex_valid = 1; ex_reg_write = 1; ex_is_uncond = 1; alu_result = 64'h42; ex_branch_target = 64'h80;
        tick("refill", 1'b1, 4'b0100);
        idle_inputs();
        ex_valid = 1; stall = 1; flush = 1; ex_set_flags = 1; ex_reg_write = 1; ex_is_uncond = 1;
        tick("stall_flush", 1'b0, 4'b0100);

        // ex_valid=0 with branch and set_flags asserted -> bubble, flags untouched
        idle_inputs();
        ex_set_flags = 1; alu_negative = 1; ex_is_uncond = 1; ex_reg_write = 1; ex_mem_write = 1;
        tick("bubble", 1'b0, 4'b0100);

`ifdef BRANCH_STATS_EN
        check("taken_count", 64'(taken_count), 64'(exp_count));
`endif

        // Reset during stall and flush
        idle_inputs();
        ex_valid = 1; ex_is_uncond = 1; alu_result = 64'h55; ex_reg_write = 1;
        tick("pre_rst", 1'b1, 4'b0100);
        idle_inputs();
        reset = 1; stall = 1; flush = 1; ex_valid = 1;
        tick("rst_mid", 1'b0, 4'b0000);
`ifdef BRANCH_STATS_EN
        check("taken_count_rst", 64'(taken_count), 64'd0);
`endif
        idle_inputs();

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/ex_mem_flags_stage.md
Name: ex_mem_flags_stage

Overview:
- Sits directly downstream of the 64-bit ALU in the pipelined CPU.
- Captures the ALU result and the N/Z/V/C flag outputs at the EX/MEM boundary.
- Owns the architectural NZCV flag register, written by flag-setting instructions (ADDS/SUBS/ANDS).
- Resolves B, B.cond, CBZ and CBNZ, and presents a registered taken/target pair to MEM for the fetch redirect.

Parameters:
- BITS, 64, data width of result, store data and branch target.
- REG_ADDR, 5, width of the destination register index.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX holds a live instruction.
- alu_result  in  BITS  ALU result.
- alu_negative  in  1  ALU negative flag.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag.
- alu_carry_out  in  1  ALU carry-out flag.
- ex_set_flags  in  1  instruction writes NZCV.
- ex_is_uncond  in  1  B / BL.
- ex_is_bcond  in  1  B.cond.
- ex_is_cbz  in  1  CBZ.
- ex_is_cbnz  in  1  CBNZ.
- ex_cond  in  4  B.cond condition field.
- ex_branch_target  in  BITS  computed target address.
- ex_store_data  in  BITS  Rt value for STUR.
- ex_rd  in  REG_ADDR  destination register.
- ex_reg_write  in  1  register write-back enable.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- stall  in  1  hold the stage.
- flush  in  1  kill the EX instruction.
- mem_valid  out  1  MEM holds a live instruction.
- mem_result  out  BITS  registered ALU result.
- mem_store_data  out  BITS  registered store data.
- mem_rd  out  REG_ADDR  registered destination register.
- mem_reg_write  out  1  registered write-back enable.
- mem_mem_read  out  1  registered load.
- mem_mem_write  out  1  registered store.
- mem_branch_taken  out  1  registered branch decision.
- mem_branch_target  out  BITS  registered target address.
- flags  out  4  architectural {N,Z,C,V}.

Behaviour:
- Priority on each posedge: reset > flush > stall > advance.
- Reset: every output is 0, including flags = 4'b0000.
- Advance (ex_valid=1, no stall, no flush):
  - All mem_* registers load their ex_* / alu_* sources; mem_valid is 1.
  - Latency is one cycle.
- Advance with ex_valid=0: a bubble.
  - mem_valid, mem_reg_write, mem_mem_read, mem_mem_write and mem_branch_taken become 0.
  - The data registers are don't-care.
- Flush: same effect on the MEM registers as a bubble. The EX instruction must NOT update flags.
- Stall: every register holds its value, including flags. Flush during stall: flush wins.
- Flag write: flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow} only when ex_valid & ex_set_flags & ~stall & ~flush.
- Branch decision, computed combinationally in EX and registered into mem_branch_taken; valid only when ex_valid:
  - ex_is_uncond: taken.
  - ex_is_cbz: taken if alu_zero (the ALU passes Rt).
  - ex_is_cbnz: taken if ~alu_zero.
  - ex_is_bcond: taken if the condition holds on the current flags register, not on this cycle's ALU flags.
  - At most one branch-type input is asserted at a time. Behaviour is undefined otherwise.
- Condition encodings (ex_cond → condition):
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 HS: C. 0011 LO: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !(C&!Z).
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: !(!Z&(N==V)).
  - 1110 and 1111: always taken.
- Back-to-back SUBS then B.cond: the flags written at the SUBS edge are visible to the B.cond in the next cycle. No flag bypass is needed.
- ex_set_flags together with a branch: the branch uses the old flags and the flags still update. This is not a legal encoding, but the behaviour is defined.
- Reset mid-stall or mid-flush: reset wins; all state returns to 0.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds output port taken_count (32 bits), reset to 0.
  - It increments on every posedge where a taken branch advances into MEM (same qualifiers as the mem_branch_taken load).
  - It holds on stall and flush, and wraps 0xFFFFFFFF → 0.
- When undefined: the port and the counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert reset 2 cycles with random inputs → all outputs 0, flags=0000. Release with ex_valid=1, alu_result=64'h1234 → mem_result=64'h1234, mem_valid=1 after one edge.
- SUBS then B.cond:
  - Cycle 1: ex_set_flags=1, alu flags N=0, Z=1, C=1, V=0 → flags=4'b0110 after the edge.
  - Cycle 2: ex_is_bcond=1, ex_cond=0000 → mem_branch_taken=1. Repeat with ex_cond=0001 → 0.
- Signed conditions: flags N=1, V=0 → LT (1011) taken, GE (1010) not taken, GT (1100) not taken, LE (1101) taken.
- CBZ/CBNZ: alu_zero=1 with ex_is_cbz → taken, target passed through. alu_zero=0 with ex_is_cbz → not taken. alu_zero=0 with ex_is_cbnz → taken.
- Stall/flush:
  - Hold stall 3 cycles → outputs and flags unchanged.
  - Flush a SUBS with ex_reg_write=1 → mem_valid=0, mem_reg_write=0, flags unchanged.
  - stall=1 and flush=1 together → bubble.
- BRANCH_STATS_EN: 5 taken and 3 not-taken branches, one taken branch flushed → taken_count=5. Preload near wrap → the counter wraps to 0.
